// File: rtl/drive_ctrl.sv
// drive_ctrl: motor direction/enable controller with synchronized, debounced
// command inputs, soft-start speed ramp and dead time before restart/reversal.
// Optional feature macro: DRIVE_CTRL_OBSTACLE_EN (obstacle input active when
// defined; when undefined the obstacle port is present but ignored).
module drive_ctrl #(
    parameter int DEB_CYC  = 50000,
    parameter int DEAD_CYC = 100000,
    parameter int RAMP_CYC = 200000
) (
    input  logic       clk1,
    input  logic       rst,
    input  logic       cmd_fwd,
    input  logic       cmd_rev,
    input  logic       cmd_fast,
    input  logic       obstacle,
    output logic       ZF,
    output logic       SP,
    output logic       EN,
    output logic [1:0] state
);

    localparam int DEB_W  = $clog2(DEB_CYC) + 1;
    localparam int DEAD_W = $clog2(DEAD_CYC) + 1;
    localparam int RAMP_W = $clog2(RAMP_CYC) + 1;

`ifdef DRIVE_CTRL_OBSTACLE_EN
    localparam int NIN = 4;
    logic [NIN-1:0] raw;
    assign raw = {obstacle, cmd_fast, cmd_rev, cmd_fwd};
`else
    localparam int NIN = 3;
    logic [NIN-1:0] raw;
    logic           unused_obstacle;
    assign raw             = {cmd_fast, cmd_rev, cmd_fwd};
    assign unused_obstacle = obstacle;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DEAD = 2'b10
    } state_t;

    logic [NIN-1:0]            sync1_q;
    logic [NIN-1:0]            sync2_q;
    logic [NIN-1:0]            deb_q;
    logic [NIN-1:0][DEB_W-1:0] deb_cnt_q;

    state_t              state_q, state_d;
    logic                zf_q, zf_d;
    logic                sp_q, sp_d;
    logic                en_q, en_d;
    logic [RAMP_W-1:0]   ramp_q, ramp_d;
    logic [DEAD_W-1:0]   dead_q, dead_d;

    logic fwd_deb, rev_deb, fast_deb, obs_deb;
    logic req_go, req_fwd;

    // Two-flop synchronizers and per-input debounce: the debounced value
    // follows the synchronized value once it has differed for DEB_CYC cycles.
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            deb_q     <= '0;
            deb_cnt_q <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            for (int i = 0; i < NIN; i++) begin
                if (sync2_q[i] != deb_q[i]) begin
                    if (deb_cnt_q[i] == DEB_W'(DEB_CYC - 1)) begin
                        deb_q[i]     <= sync2_q[i];
                        deb_cnt_q[i] <= '0;
                    end else begin
                        deb_cnt_q[i] <= deb_cnt_q[i] + DEB_W'(1);
                    end
                end else begin
                    deb_cnt_q[i] <= '0;
                end
            end
        end
    end

    assign fwd_deb  = deb_q[0];
    assign rev_deb  = deb_q[1];
    assign fast_deb = deb_q[2];
`ifdef DRIVE_CTRL_OBSTACLE_EN
    assign obs_deb  = deb_q[3];
`else
    assign obs_deb  = 1'b0;
`endif

    // Exactly one of fwd/rev set is a valid direction request; otherwise STOP.
    assign req_go  = fwd_deb ^ rev_deb;
    assign req_fwd = fwd_deb & ~rev_deb;

    // Next-state and registered-output logic for IDLE/RUN/DEAD.
    always_comb begin
        state_d = state_q;
        zf_d    = zf_q;
        sp_d    = 1'b0;
        en_d    = 1'b0;
        ramp_d  = ramp_q;
        dead_d  = dead_q;
        case (state_q)
            IDLE: begin
                if (req_go && !obs_deb) begin
                    state_d = RUN;
                    zf_d    = req_fwd;
                    ramp_d  = RAMP_W'(RAMP_CYC);
                    en_d    = 1'b1;
                    sp_d    = fast_deb && (ramp_d == '0);
                end
            end
            RUN: begin
                if (!req_go || obs_deb || (req_fwd != zf_q)) begin
                    // Obstacle and direction change together still make one exit.
                    state_d = DEAD;
                    dead_d  = DEAD_W'(DEAD_CYC);
                end else begin
                    en_d   = 1'b1;
                    ramp_d = (ramp_q == '0) ? '0 : ramp_q - RAMP_W'(1);
                    sp_d   = fast_deb && (ramp_d == '0);
                end
            end
            DEAD: begin
                if (dead_q == '0) begin
                    state_d = IDLE;
                end else begin
                    dead_d = dead_q - DEAD_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset drops EN immediately.
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            zf_q    <= 1'b1;
            sp_q    <= 1'b0;
            en_q    <= 1'b0;
            ramp_q  <= '0;
            dead_q  <= '0;
        end else begin
            state_q <= state_d;
            zf_q    <= zf_d;
            sp_q    <= sp_d;
            en_q    <= en_d;
            ramp_q  <= ramp_d;
            dead_q  <= dead_d;
        end
    end

    assign ZF    = zf_q;
    assign SP    = sp_q;
    assign EN    = en_q;
    assign state = state_q;

endmodule
